// File: rtl/shift_reg_universal.sv
// Universal serial/parallel converter: SIPO receive (mode=0) and PISO transmit (mode=1).
// PISO handshake: a word is taken on any edge where i_pin_load && o_pin_ready; there is no queue.
module shift_reg_universal #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mode,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    output logic [WIDTH-1:0] o_pout,
    output logic             o_pout_valid,
    input  logic [WIDTH-1:0] i_pin,
    input  logic             i_pin_load,
    output logic             o_pin_ready,
    output logic             o_sout,
    output logic             o_sout_valid,
    output logic             o_busy,
    output logic [0:0]       o_dbg_state
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE     = CW'(1);
    localparam logic [0:0]     S_IDLE  = 1'b0;
    localparam logic [0:0]     S_SHIFT = 1'b1;

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [0:0]       r_state;
    logic             r_mode_q;
    logic [WIDTH-1:0] r_pout;
    logic             r_pout_valid;
    logic             r_sout_valid;

    logic             w_mode_chg;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_sipo_next;
    logic [WIDTH-1:0] w_piso_next;

    assign w_mode_chg  = (i_mode != r_mode_q);
    assign w_last      = (r_cnt == LAST);
    assign w_sipo_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], i_sin} : {i_sin, r_shreg[WIDTH-1:1]};
    assign w_piso_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
    assign w_load      = i_pin_load && o_pin_ready && !w_mode_chg;

    // Ready is the only output allowed to see inputs (rst, mode) combinationally.
    assign o_pin_ready  = rst && i_mode && ((r_state == S_IDLE) || ((r_state == S_SHIFT) && w_last));
    assign o_sout       = (r_state == S_SHIFT) && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
    assign o_busy       = (!r_mode_q && (r_cnt != '0)) || (r_mode_q && (r_state == S_SHIFT));
    assign o_pout       = r_pout;
    assign o_pout_valid = r_pout_valid;
    assign o_sout_valid = r_sout_valid;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
            r_mode_q     <= i_mode;
            r_pout       <= '0;
            r_pout_valid <= 1'b0;
            r_sout_valid <= 1'b0;
        end else begin
            r_mode_q     <= i_mode;
            r_pout_valid <= 1'b0;
            if (w_mode_chg) begin
                // Switching direction drops any partial frame but keeps the last received word.
                r_shreg      <= '0;
                r_cnt        <= '0;
                r_state      <= S_IDLE;
                r_sout_valid <= 1'b0;
            end else if (!i_mode) begin
                if (i_sin_valid) begin
                    r_shreg <= w_sipo_next;
                    if (w_last) begin
                        r_pout       <= w_sipo_next;
                        r_pout_valid <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_load) begin
                            r_shreg      <= i_pin;
                            r_cnt        <= '0;
                            r_state      <= S_SHIFT;
                            r_sout_valid <= 1'b1;
                        end
                    end
                    default: begin
                        if (w_last) begin
                            // Last bit on the wire: chain straight into the next word if offered.
                            if (w_load) begin
                                r_shreg <= i_pin;
                                r_cnt   <= '0;
                            end else begin
                                r_shreg      <= w_piso_next;
                                r_cnt        <= '0;
                                r_state      <= S_IDLE;
                                r_sout_valid <= 1'b0;
                            end
                        end else begin
                            r_shreg <= w_piso_next;
                            r_cnt   <= r_cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench: one MSB-first and one LSB-first instance driven by the same stimulus.
module tb_shift_reg_universal;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_mode, i_sin, i_sin_valid, i_pin_load;
    logic [7:0] i_pin;

    logic [7:0] pout_m, pout_l;
    logic       pv_m, pv_l, rdy_m, rdy_l, so_m, so_l, sv_m, sv_l, busy_m, busy_l;
    logic [0:0] st_m, st_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_reg_universal #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_sin(i_sin), .i_sin_valid(i_sin_valid),
        .o_pout(pout_m), .o_pout_valid(pv_m), .i_pin(i_pin), .i_pin_load(i_pin_load),
        .o_pin_ready(rdy_m), .o_sout(so_m), .o_sout_valid(sv_m), .o_busy(busy_m),
        .o_dbg_state(st_m)
    );

    shift_reg_universal #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_sin(i_sin), .i_sin_valid(i_sin_valid),
        .o_pout(pout_l), .o_pout_valid(pv_l), .i_pin(i_pin), .i_pin_load(i_pin_load),
        .o_pin_ready(rdy_l), .o_sout(so_l), .o_sout_valid(sv_l), .o_busy(busy_l),
        .o_dbg_state(st_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // s[7] is the first serial bit; gap_at inserts 3 idle cycles after that bit index.
    task automatic sipo_frame(input logic [7:0] s, input int gap_at,
                              input logic [7:0] exp_m, input logic [7:0] exp_l);
        for (int i = 0; i < 8; i++) begin
            i_sin = s[7-i];
            i_sin_valid = 1'b1;
            tick();
            check("sipo_pv_m", 32'(pv_m), 32'(i == 7));
            check("sipo_pv_l", 32'(pv_l), 32'(i == 7));
            check("sipo_busy_m", 32'(busy_m), 32'(i != 7));
            check("sipo_busy_l", 32'(busy_l), 32'(i != 7));
            if (i == gap_at) begin
                i_sin_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("gap_pv_m", 32'(pv_m), 32'd0);
                    check("gap_busy_m", 32'(busy_m), 32'd1);
                    check("gap_busy_l", 32'(busy_l), 32'd1);
                end
            end
        end
        check("sipo_pout_m", 32'(pout_m), 32'(exp_m));
        check("sipo_pout_l", 32'(pout_l), 32'(exp_l));
        i_sin_valid = 1'b0;
        tick();
        check("sipo_pulse_end_m", 32'(pv_m), 32'd0);
        check("sipo_pulse_end_l", 32'(pv_l), 32'd0);
        check("sipo_hold_m", 32'(pout_m), 32'(exp_m));
    endtask

    // Observes the 8 bit-cycles of a frame already loaded; sets up the input for each following edge.
    task automatic piso_frame(input logic [7:0] w, input logic hold, input logic chain,
                              input logic [7:0] next_w);
        for (int i = 0; i < 8; i++) begin
            check("piso_sv_m", 32'(sv_m), 32'd1);
            check("piso_sv_l", 32'(sv_l), 32'd1);
            check("piso_so_m", 32'(so_m), 32'(w[7-i]));
            check("piso_so_l", 32'(so_l), 32'(w[i]));
            check("piso_rdy_m", 32'(rdy_m), 32'(i == 7));
            check("piso_busy_m", 32'(busy_m), 32'd1);
            if (i == 7) begin
                i_pin_load = chain;
                i_pin      = next_w;
            end else begin
                i_pin_load = hold;
                i_pin      = 8'hFF;
            end
            tick();
        end
    endtask

    task automatic check_piso_idle(input string tag);
        check({tag, "_sv_m"}, 32'(sv_m), 32'd0);
        check({tag, "_so_m"}, 32'(so_m), 32'd0);
        check({tag, "_busy_m"}, 32'(busy_m), 32'd0);
        check({tag, "_rdy_m"}, 32'(rdy_m), 32'd1);
        check({tag, "_st_m"}, 32'(st_m), 32'd0);
    endtask

    initial begin
        rst = 1'b0; i_mode = 1'b0; i_sin = 1'b0; i_sin_valid = 1'b0;
        i_pin_load = 1'b0; i_pin = 8'h00;
        tick();
        tick();
        check("rst_pout_m", 32'(pout_m), 32'd0);
        check("rst_pv_m", 32'(pv_m), 32'd0);
        check("rst_sv_m", 32'(sv_m), 32'd0);
        check("rst_so_m", 32'(so_m), 32'd0);
        check("rst_busy_m", 32'(busy_m), 32'd0);
        check("rst_rdy_m", 32'(rdy_m), 32'd0);
        check("rst_st_m", 32'(st_m), 32'd0);
        rst = 1'b1;
        tick();

        // Stream 1,0,1,1,0,0,1,0: MSB-first B2, LSB-first 4D.
        sipo_frame(8'hB2, -1, 8'hB2, 8'h4D);
        sipo_frame(8'hB2, 3, 8'hB2, 8'h4D);

        // Partial frame discarded by a mode round trip; sin_valid held high across the toggles.
        for (int i = 0; i < 5; i++) begin
            i_sin = 1'b1;
            i_sin_valid = 1'b1;
            tick();
        end
        check("part_busy_m", 32'(busy_m), 32'd1);
        i_mode = 1'b1;
        tick();
        check("tog1_pv_m", 32'(pv_m), 32'd0);
        check("tog1_busy_m", 32'(busy_m), 32'd0);
        check("tog1_pout_m", 32'(pout_m), 32'hB2);
        check("tog1_pout_l", 32'(pout_l), 32'h4D);
        i_mode = 1'b0;
        tick();
        check("tog0_pv_m", 32'(pv_m), 32'd0);
        check("tog0_busy_m", 32'(busy_m), 32'd0);
        // Fresh stream 0,1,0,1,1,1,0,0: MSB-first 5C, LSB-first 3A.
        sipo_frame(8'h5C, -1, 8'h5C, 8'h3A);

        // PISO: A5 then 3C chained on the last-bit cycle.
        i_mode = 1'b1;
        tick();
        check("piso_entry_rdy_m", 32'(rdy_m), 32'd1);
        check("piso_entry_sv_m", 32'(sv_m), 32'd0);
        i_pin = 8'hA5;
        i_pin_load = 1'b1;
        tick();
        piso_frame(8'hA5, 1'b0, 1'b1, 8'h3C);
        piso_frame(8'h3C, 1'b0, 1'b0, 8'h00);
        check_piso_idle("after_chain");

        // 01 is asymmetric, so it separates the two bit orders; load held high mid-frame is ignored.
        i_pin = 8'h01;
        i_pin_load = 1'b1;
        tick();
        piso_frame(8'h01, 1'b1, 1'b0, 8'h00);
        check_piso_idle("after_hold");
        tick();
        check_piso_idle("still_idle");

        // Reset in the middle of a frame.
        i_pin = 8'hA5;
        i_pin_load = 1'b1;
        tick();
        i_pin_load = 1'b0;
        tick();
        tick();
        check("mid_busy_m", 32'(busy_m), 32'd1);
        rst = 1'b0;
        tick();
        check("midrst_sv_m", 32'(sv_m), 32'd0);
        check("midrst_sv_l", 32'(sv_l), 32'd0);
        check("midrst_busy_m", 32'(busy_m), 32'd0);
        check("midrst_pout_m", 32'(pout_m), 32'd0);
        check("midrst_st_m", 32'(st_m), 32'd0);
        check("midrst_rdy_m", 32'(rdy_m), 32'd0);
        rst = 1'b1;
        tick();
        check_piso_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised bidirectional serial/parallel converter with two modes. In receive mode (SIPO) it assembles WIDTH-bit words from a qualified serial stream and emits them with a one-cycle valid pulse. In transmit mode (PISO) it accepts a parallel word through a ready/load handshake and shifts it out with a per-bit valid. It is the general-purpose serialiser/deserialiser used between serial links and word-wide datapaths.

## Interface
- WIDTH, 8, word length in bits; legal range 2–32.
- MSB_FIRST, 1, bit order: 1 = first serial bit is word bit WIDTH-1; 0 = first serial bit is word bit 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- mode  in  1  0 = SIPO receive, 1 = PISO transmit.
- sin  in  1  serial data in (SIPO).
- sin_valid  in  1  qualifies sin; a bit is shifted only when this is high.
- pout  out  WIDTH  last completed received word; holds until the next frame completes.
- pout_valid  out  1  one-cycle pulse when pout updates.
- pin  in  WIDTH  parallel word to transmit.
- pin_load  in  1  load request; accepted when pin_load && pin_ready.
- pin_ready  out  1  transmitter can accept a word this cycle.
- sout  out  1  serial data out (PISO).
- sout_valid  out  1  sout carries a frame bit this cycle.
- busy  out  1  a partial SIPO frame is held, or a PISO frame is in progress.

## Operation
- Internal state:
  - WIDTH-bit shift register `shreg`.
  - Bit counter `cnt`, clog2(WIDTH) bits, range 0..WIDTH-1.
  - PISO state machine: IDLE or SHIFT.
  - Registered copy of `mode`, used to detect mode changes.
- Reset (rst=0 at an edge):
  - shreg, cnt, pout, pout_valid, sout_valid all go to 0; state goes to IDLE.
  - sout=0, busy=0.
  - pin_ready is forced to 0 while rst=0.
- SIPO (mode=0), on each edge with sin_valid=1:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
  - cnt increments.
  - When cnt==WIDTH-1: pout <= the shifted value including the current bit, pout_valid <= 1, and cnt wraps to 0.
- SIPO, sin_valid=0: shreg and cnt hold; frames may be gapped arbitrarily.
- pout_valid is 1 for exactly one cycle per completed frame and 0 otherwise.
- PISO (mode=1), state machine:
  - IDLE: pin_ready=1. If pin_load, then shreg <= pin, cnt <= 0, go to SHIFT.
  - SHIFT: sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]; sout_valid=1.
  - Each SHIFT cycle, shreg shifts toward the output end (zero fill) and cnt increments.
  - At cnt==WIDTH-1 (last bit on sout): pin_ready=1.
    - If pin_load is high, load pin, reset cnt to 0 and stay in SHIFT (gapless back-to-back frames).
    - Otherwise go to IDLE.
  - pin_load while pin_ready=0 is ignored; there is no queue.
- sout = 0 and sout_valid = 0 in IDLE and in SIPO mode.
- Mode change (mode differs from its registered copy) at an edge:
  - cnt goes to 0, state goes to IDLE, shreg goes to 0; any partial frame is discarded.
  - pout is retained; no pout_valid pulse is generated.
  - sin_valid and pin_load are ignored on that edge.
- pin_ready = rst && mode && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
- busy = (mode==0 && cnt!=0) || (mode==1 && state==SHIFT).

## Timing
- SIPO latency: if the WIDTH-th bit is sampled at edge N, pout and pout_valid are visible in the cycle after edge N.
- Continuous input produces one pout_valid every WIDTH cycles.
- PISO latency: a load accepted at edge N puts the first bit on sout in the cycle after edge N, and sout_valid stays high for exactly WIDTH cycles.
- Back-to-back PISO: throughput is one bit per cycle with no idle cycle between frames.
- Reset mid-frame: all outputs reach their reset values in the cycle after the reset edge.
- A frame in progress is lost on reset; the first post-reset frame starts at cnt=0.
- All outputs except pin_ready, sout and busy are registered. Those three are decoded directly from registers only, with no input-to-output combinational path except rst and mode into pin_ready.

## Test plan
- WIDTH=8, MSB_FIRST=1, SIPO, continuous bits 1,0,1,1,0,0,1,0 -> pout=8'hB2, pout_valid high for exactly one cycle after the 8th edge.
- WIDTH=8, MSB_FIRST=0, same stream -> pout=8'h4D; repeat with sin_valid low for 3 cycles after bit 4 -> same pout, pulse delayed by 3 cycles, busy=1 during the gap.
- PISO, MSB_FIRST=1, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 with sout_valid high for 8 cycles; then pin_load with 8'h3C on the last-bit cycle -> 0,0,1,1,1,1,0,0 follows with no gap and sout_valid never drops.
- PISO, pin_load held high during SHIFT before the last bit -> ignored; exactly one frame is sent per accepted load.
- SIPO: 5 bits received, then mode toggled to 1 and back to 0, then 8 fresh bits -> pout reflects only the fresh 8 bits, and no spurious pout_valid occurs.
- rst=0 asserted for 1 cycle mid PISO frame -> next cycle sout_valid=0, busy=0, pout=0, state IDLE; pin_ready=1 the following cycle with mode=1.
